// File: rtl/pc_src_predictor.sv
// Control-transfer unit: jump/branch classification, 2-bit counter prediction,
// training at resolve, and a fixed-length pipeline flush on misprediction.
module pc_src_predictor #(
  parameter int         PC_WIDTH     = 16,
  parameter int         IDX_BITS     = 4,
  parameter logic [1:0] CTR_INIT     = 2'b01,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_valid,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  input  logic [4:0]           fetch_opcode,
  output logic                 is_ctrl,
  output logic                 pred_taken,
  input  logic                 resolve_valid,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic [4:0]           resolve_opcode,
  input  logic                 resolve_taken,
  input  logic                 resolve_pred,
  output logic                 mispredict,
  output logic                 flush,
  output logic [CNT_WIDTH-1:0] ctrl_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t state, state_next;
  logic [3:0] down, down_next;
  logic [1:0] ctr [DEPTH];

  logic f_jump, f_branch;
  logic r_jump, r_branch, r_ctrl;
  logic [IDX_BITS-1:0] f_idx, r_idx;
  logic accept, miss;

  assign f_jump   = fetch_opcode[4:2] == 3'b001;
  assign f_branch = fetch_opcode[4:2] == 3'b011;
  assign r_jump   = resolve_opcode[4:2] == 3'b001;
  assign r_branch = resolve_opcode[4:2] == 3'b011;
  assign r_ctrl   = r_jump | r_branch;

  // pc[0] is ignored: instructions are 2-byte aligned
  assign f_idx = fetch_pc[IDX_BITS:1];
  assign r_idx = resolve_pc[IDX_BITS:1];

  assign is_ctrl = f_jump | f_branch;
  assign pred_taken = fetch_valid && (state == IDLE)
                   && (f_jump || (f_branch && ctr[f_idx][1]));

  assign accept = resolve_valid && r_ctrl && (state == IDLE);
  assign miss   = accept && (resolve_taken != resolve_pred);
  assign flush  = (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      down  <= '0;
    end else begin
      state <= state_next;
      down  <= down_next;
    end
  end

  always_comb begin
    state_next = state;
    down_next  = down;
    unique case (state)
      IDLE: begin
        if (miss) begin
          state_next = FLUSH;
          down_next  = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        down_next = down - 4'd1;
        if (down == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict <= 1'b0;
      ctrl_count <= '0;
      miss_count <= '0;
    end else begin
      mispredict <= miss;
      if (accept && !(&ctrl_count))
        ctrl_count <= ctrl_count + 1'b1;
      if (miss && !(&miss_count))
        miss_count <= miss_count + 1'b1;
    end
  end

  // Only branches train; jumps are always predicted taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        ctr[i] <= CTR_INIT;
    end else if (accept && r_branch) begin
      if (resolve_taken && ctr[r_idx] != 2'b11)
        ctr[r_idx] <= ctr[r_idx] + 2'b01;
      else if (!resolve_taken && ctr[r_idx] != 2'b00)
        ctr[r_idx] <= ctr[r_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_pc_src_predictor.sv
// Bench for pc_src_predictor: directed steps plus random traffic
// compared against a behavioural model of the predictor.
module tb_pc_src_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_pc = '0;
  logic [4:0]  fetch_opcode = '0;
  logic        resolve_valid = 1'b0;
  logic [15:0] resolve_pc = '0;
  logic [4:0]  resolve_opcode = '0;
  logic        resolve_taken = 1'b0;
  logic        resolve_pred = 1'b0;

  logic        is_ctrl, pred_taken, mispredict, flush;
  logic [15:0] ctrl_count, miss_count;
  logic        s_is_ctrl, s_pred_taken, s_mispredict, s_flush;
  logic [1:0]  s_ctrl_count, s_miss_count;

  int n_checks = 0;
  int n_errors = 0;

  int m_ctr [16];
  int m_flush_left;
  int m_mis;
  int m_ctrl;
  int m_miss;

  always #5 clk = ~clk;

  pc_src_predictor dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_opcode(fetch_opcode),
    .is_ctrl(is_ctrl), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_opcode(resolve_opcode),
    .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
    .mispredict(mispredict), .flush(flush),
    .ctrl_count(ctrl_count), .miss_count(miss_count)
  );

  pc_src_predictor #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_opcode(fetch_opcode),
    .is_ctrl(s_is_ctrl), .pred_taken(s_pred_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_opcode(resolve_opcode),
    .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
    .mispredict(s_mispredict), .flush(s_flush),
    .ctrl_count(s_ctrl_count), .miss_count(s_miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int is_jump(input logic [4:0] op);
    return (op >= 5'd4 && op <= 5'd7) ? 1 : 0;
  endfunction

  function automatic int is_branch(input logic [4:0] op);
    return (op >= 5'd12 && op <= 5'd15) ? 1 : 0;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    m_flush_left = 0;
    m_mis = 0;
    m_ctrl = 0;
    m_miss = 0;
  endtask

  task automatic check_all();
    int ep;
    int idx;
    idx = int'(fetch_pc[4:1]);
    ep = 0;
    if (fetch_valid && m_flush_left == 0) begin
      if (is_jump(fetch_opcode) != 0) ep = 1;
      if (is_branch(fetch_opcode) != 0 && m_ctr[idx] >= 2) ep = 1;
    end
    chk("is_ctrl", 32'(is_ctrl),
        32'(is_jump(fetch_opcode) | is_branch(fetch_opcode)));
    chk("pred_taken", 32'(pred_taken), 32'(ep));
    chk("mispredict", 32'(mispredict), 32'(m_mis));
    chk("flush", 32'(flush), 32'(m_flush_left > 0));
    chk("ctrl_count", 32'(ctrl_count), 32'(sat(m_ctrl, 65535)));
    chk("miss_count", 32'(miss_count), 32'(sat(m_miss, 65535)));
    chk("sat_ctrl", 32'(s_ctrl_count), 32'(sat(m_ctrl, 3)));
    chk("sat_miss", 32'(s_miss_count), 32'(sat(m_miss, 3)));
  endtask

  task automatic model_edge();
    int acc;
    int idx;
    idx = int'(resolve_pc[4:1]);
    acc = (resolve_valid && m_flush_left == 0 &&
           (is_jump(resolve_opcode) | is_branch(resolve_opcode)) != 0)
          ? 1 : 0;
    m_mis = 0;
    if (m_flush_left > 0) m_flush_left--;
    if (acc != 0) begin
      m_ctrl++;
      if (is_branch(resolve_opcode) != 0) begin
        if (resolve_taken) m_ctr[idx] = sat(m_ctr[idx] + 1, 3);
        else if (m_ctr[idx] > 0) m_ctr[idx]--;
      end
      if (resolve_taken != resolve_pred) begin
        m_miss++;
        m_mis = 1;
        m_flush_left = 2;
      end
    end
  endtask

  task automatic cyc(input logic fv, input logic [15:0] fpc,
                     input logic [4:0] fop, input logic rv,
                     input logic [15:0] rpc, input logic [4:0] rop,
                     input logic rt, input logic rp);
    @(negedge clk);
    fetch_valid = fv;
    fetch_pc = fpc;
    fetch_opcode = fop;
    resolve_valid = rv;
    resolve_pc = rpc;
    resolve_opcode = rop;
    resolve_taken = rt;
    resolve_pred = rp;
    #1;
    check_all();
    model_edge();
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 5'h10, 1'b0, 16'h0, 5'h10, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    cyc(1'b1, 16'h0010, 5'b01100, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("br_init_ctrl", 32'(is_ctrl), 32'd1);
    chk("br_init_pred", 32'(pred_taken), 32'd0);
    cyc(1'b1, 16'h0010, 5'b00101, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("jmp_pred", 32'(pred_taken), 32'd1);
    cyc(1'b1, 16'h0010, 5'b10000, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("nonctrl_ctrl", 32'(is_ctrl), 32'd0);

    repeat (3)
      cyc(1'b0, 16'h0, 5'h0, 1'b1, 16'h0020, 5'b01101, 1'b1, 1'b1);
    cyc(1'b1, 16'h0020, 5'b01101, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("trained_pred", 32'(pred_taken), 32'd1);
    chk("ctrl3", 32'(ctrl_count), 32'd3);
    chk("miss0", 32'(miss_count), 32'd0);

    cyc(1'b0, 16'h0, 5'h0, 1'b1, 16'h0040, 5'b01110, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 5'h0, 1'b1, 16'h0040, 5'b01111, 1'b0, 1'b1);
    chk("mis_n1", 32'(mispredict), 32'd1);
    chk("flush_n1", 32'(flush), 32'd1);
    idle();
    chk("mis_n2", 32'(mispredict), 32'd0);
    chk("flush_n2", 32'(flush), 32'd1);
    idle();
    chk("flush_n3", 32'(flush), 32'd0);
    chk("miss1", 32'(miss_count), 32'd1);
    chk("ctrl4", 32'(ctrl_count), 32'd4);

    cyc(1'b1, 16'h0030, 5'b01100, 1'b1, 16'h0030, 5'b01100, 1'b1, 1'b1);
    chk("same_cyc_pre", 32'(pred_taken), 32'd0);
    cyc(1'b1, 16'h0030, 5'b01100, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("same_cyc_post", 32'(pred_taken), 32'd1);

    cyc(1'b0, 16'h0, 5'h0, 1'b1, 16'h0020, 5'b00100, 1'b1, 1'b0);
    idle();
    chk("pre_rst_flush", 32'(flush), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(mispredict), 32'd0);
    chk("rst_ctrl", 32'(ctrl_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 16'h0020, 5'b01101, 1'b0, 16'h0, 5'h0, 1'b0, 1'b0);
    chk("rst_table", 32'(pred_taken), 32'd0);

    repeat (5)
      cyc(1'b0, 16'h0, 5'h0, 1'b1, 16'h0022, 5'b00110, 1'b1, 1'b1);
    idle();
    chk("sat_hold", 32'(s_ctrl_count), 32'd3);
    chk("wide_ctrl5", 32'(ctrl_count), 32'd5);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] fop, rop;
      fop = 5'($urandom_range(0, 31));
      rop = ($urandom_range(0, 3) != 0)
          ? 5'($urandom_range(12, 15)) : 5'($urandom_range(0, 31));
      cyc(1'($urandom), 16'($urandom_range(0, 63)), fop,
          1'($urandom), 16'($urandom_range(0, 63)), rop,
          1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
